// File: rtl/sram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_arb_pkg                                                             |
// | Shared types, constants and round-robin helper for sram_port_arbiter.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sram_arb_pkg;

    localparam int MAX_REQ     = 8;
    localparam int IDX_W       = 3;
    localparam int SRAM_ADDR_W = 19;
    localparam int SRAM_DATA_W = 64;
    localparam int SRAM_BE_W   = SRAM_DATA_W / 8;

    localparam logic [1:0] SRAM_OE_READ = 2'b11;
    localparam logic [1:0] SRAM_OE_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_TURN = 2'd3
    } arb_state_t;

    // Field widths follow the board SRAM geometry.
    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [SRAM_BE_W-1:0]   be;
    } cmd_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First asserted requester at or after ptr, wrapping modulo n.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        rr_pick_t pick;
        int       j;
        pick.found = 1'b0;
        pick.idx   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (int'(ptr) + k) % n;
            if ((k < n) && !pick.found && valid[IDX_W'(j)]) begin
                pick.found = 1'b1;
                pick.idx   = IDX_W'(j);
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arb_rsp_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_arb_rsp_pipe                                                        |
// | Read-tag delay line; captures SRAM read data when a tag falls out.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_arb_rsp_pipe
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [IDX_W-1:0]   i_push_id,
    input  logic [DATA_W-1:0]  i_sram_data_in,
    output logic [NUM_REQ-1:0] o_rsp_valid,
    output logic [DATA_W-1:0]  o_rsp_rdata
);

    localparam int c_depth = RD_LAT + 1;

    logic [c_depth-1:0] r_tag_vld;
    logic [IDX_W-1:0]   r_tag_id [c_depth];
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld   <= '0;
            for (int k = 0; k < c_depth; k++) begin
                r_tag_id[k] <= '0;
            end
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_tag_vld   <= {r_tag_vld[c_depth-2:0], i_push};
            r_tag_id[0] <= i_push_id;
            for (int k = 1; k < c_depth; k++) begin
                r_tag_id[k] <= r_tag_id[k-1];
            end
            // Read data is only meaningful on the cycle its tag exits.
            if (r_tag_vld[c_depth-1]) begin
                r_rsp_valid <= NUM_REQ'(1) << r_tag_id[c_depth-1];
                r_rsp_rdata <= i_sram_data_in;
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sram_port_arbiter                                                        |
// | Round-robin sharing of one SRAM port with read->write turnaround.        |
// | Optional SRAM_ARB_PERF_EN adds stall_cycles / turn_count counters.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SRAM_ADDR_W,
    parameter int DATA_W  = SRAM_DATA_W,
    parameter int RD_LAT  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0] req_be,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic [ADDR_W-1:0]             sram_addr,
    output logic [DATA_W-1:0]             sram_data_out,
    output logic [DATA_W/8-1:0]           sram_we,
    output logic [1:0]                    sram_oe,
    input  logic [DATA_W-1:0]             sram_data_in
`ifdef SRAM_ARB_PERF_EN
    ,
    output logic [31:0]                   stall_cycles,
    output logic [15:0]                   turn_count
`endif
);

    localparam int c_be_w = DATA_W / 8;

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [IDX_W-1:0]    r_ptr;
    rr_pick_t            w_pick;
    logic [MAX_REQ-1:0]  w_we_pad;
    cmd_t                w_cmd;
    logic                w_turn;
    logic                w_xfer;

    logic [ADDR_W-1:0]   r_sram_addr;
    logic [DATA_W-1:0]   r_sram_data_out;
    logic [c_be_w-1:0]   r_sram_we;
    logic [1:0]          r_sram_oe;

    assign w_pick   = rr_pick(MAX_REQ'(req_valid), r_ptr, NUM_REQ);
    assign w_we_pad = MAX_REQ'(req_we);

    always_comb begin
        w_cmd       = '0;
        w_cmd.we    = w_we_pad[w_pick.idx];
        w_cmd.addr  = SRAM_ADDR_W'(req_addr[w_pick.idx*ADDR_W +: ADDR_W]);
        w_cmd.wdata = SRAM_DATA_W'(req_wdata[w_pick.idx*DATA_W +: DATA_W]);
        w_cmd.be    = SRAM_BE_W'(req_be[w_pick.idx*c_be_w +: c_be_w]);
    end

    // A write may not go to the pins directly behind a read still driving oe.
    assign w_turn    = (r_state == ST_RD) && w_pick.found && w_cmd.we;
    assign w_xfer    = w_pick.found && !w_turn && !reset;
    assign req_ready = w_xfer ? (NUM_REQ'(1) << w_pick.idx) : '0;

    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_xfer) begin
            w_state_nxt = w_cmd.we ? ST_WR : ST_RD;
        end else if (w_turn) begin
            w_state_nxt = ST_TURN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) begin
                if (w_pick.idx == IDX_W'(NUM_REQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_pick.idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sram_addr     <= '0;
            r_sram_data_out <= '0;
            r_sram_we       <= '0;
            r_sram_oe       <= SRAM_OE_IDLE;
        end else if (w_xfer) begin
            r_sram_addr     <= ADDR_W'(w_cmd.addr);
            r_sram_data_out <= DATA_W'(w_cmd.wdata);
            r_sram_we       <= w_cmd.we ? c_be_w'(w_cmd.be) : '0;
            r_sram_oe       <= w_cmd.we ? SRAM_OE_IDLE : SRAM_OE_READ;
        end else begin
            r_sram_we       <= '0;
            r_sram_oe       <= SRAM_OE_IDLE;
        end
    end

    assign sram_addr     = r_sram_addr;
    assign sram_data_out = r_sram_data_out;
    assign sram_we       = r_sram_we;
    assign sram_oe       = r_sram_oe;

    sram_arb_rsp_pipe #(
        .NUM_REQ (NUM_REQ),
        .DATA_W  (DATA_W),
        .RD_LAT  (RD_LAT)
    ) u_rsp_pipe (
        .clk            (clk),
        .rst            (reset),
        .i_push         (w_xfer && !w_cmd.we),
        .i_push_id      (w_pick.idx),
        .i_sram_data_in (sram_data_in),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_rdata    (rsp_rdata)
    );

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [15:0] r_turn_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cycles <= '0;
            r_turn_count   <= '0;
        end else begin
            if ((|req_valid) && !w_xfer && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_turn && (r_turn_count != '1)) begin
                r_turn_count <= r_turn_count + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign turn_count   = r_turn_count;
`endif

endmodule
`default_nettype wire
